// File: rtl/dpd_conv_pkg.sv
// Shared constants for the decimal format converter: format codes,
// FSM state codes and width helpers derived from the declet count.
package dpd_conv_pkg;

   localparam logic [1:0] FMT_BIN     = 2'b00;
   localparam logic [1:0] FMT_BCD     = 2'b01;
   localparam logic [1:0] FMT_DPD     = 2'b10;
   localparam logic [1:0] FMT_DPD_ALT = 2'b11;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BIN2BCD = 2'd1;
   localparam logic [1:0] ST_BCD2BIN = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   function automatic int dig_cnt(input int ndec);
      return 3 * ndec;
   endfunction

   function automatic int bin_w(input int ndec);
      return 10 * ndec;
   endfunction

   function automatic int bcd_w(input int ndec);
      return 12 * ndec;
   endfunction

endpackage

// File: rtl/dpd_conv_seq_dabble_step.sv
// Double-dabble correction: adds 3 to every BCD digit that is 5 or more,
// ahead of the one-bit left shift done by the caller.
module bcd_dabble_step #(
   parameter int NDIG = 7
) (
   input  logic [4*NDIG-1:0] i_dig,
   output logic [4*NDIG-1:0] o_dig
);

   for (genvar g = 0; g < NDIG; g++) begin : g_dig
      assign o_dig[4*g +: 4] = (i_dig[4*g +: 4] >= 4'd5) ? i_dig[4*g +: 4] + 4'd3
                                                          : i_dig[4*g +: 4];
   end

endmodule

// File: rtl/dpd_pack.sv
// Packs three BCD digits into one 10-bit DPD declet. Digits 8..15 count as
// large and contribute only their LSB, so 10..15 encode as 8 or 9.
module dpd_pack (
   input  logic [11:0] i_bcd,
   output logic [9:0]  o_dpd
);

   logic       w_bh, w_bt, w_bu;
   logic [2:0] w_h, w_t, w_u;

   assign {w_bh, w_h} = i_bcd[11:8];
   assign {w_bt, w_t} = i_bcd[7:4];
   assign {w_bu, w_u} = i_bcd[3:0];

   always_comb begin
      case ({w_bh, w_bt, w_bu})
         3'b000:  o_dpd = {w_h, w_t, 1'b0, w_u};
         3'b001:  o_dpd = {w_h, w_t, 3'b100, w_u[0]};
         3'b010:  o_dpd = {w_h, w_u[2:1], w_t[0], 3'b101, w_u[0]};
         3'b011:  o_dpd = {w_h, 2'b10, w_t[0], 3'b111, w_u[0]};
         3'b100:  o_dpd = {w_u[2:1], w_h[0], w_t, 3'b110, w_u[0]};
         3'b101:  o_dpd = {w_t[2:1], w_h[0], 2'b01, w_t[0], 3'b111, w_u[0]};
         3'b110:  o_dpd = {w_u[2:1], w_h[0], 2'b00, w_t[0], 3'b111, w_u[0]};
         default: o_dpd = {2'b00, w_h[0], 2'b11, w_t[0], 3'b111, w_u[0]};
      endcase
   end

endmodule

// File: rtl/dpd_unpack.sv
// Unpacks one 10-bit DPD declet into three BCD digits. Non-canonical codes
// decode by the standard rules (the ignored bits simply drop out).
module dpd_unpack (
   input  logic [9:0]  i_dpd,
   output logic [11:0] o_bcd
);

   logic [3:0] w_h, w_t, w_u;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      w_h = {1'b0, i_dpd[9:7]};
      w_t = {1'b0, i_dpd[6:4]};
      w_u = {1'b0, i_dpd[2:0]};
      if (i_dpd[3]) begin
         case (i_dpd[2:1])
            2'b00: w_u = {3'b100, i_dpd[0]};
            2'b01: begin
               w_t = {3'b100, i_dpd[4]};
               w_u = {1'b0, i_dpd[6:5], i_dpd[0]};
            end
            2'b10: begin
               w_h = {3'b100, i_dpd[7]};
               w_u = {1'b0, i_dpd[9:8], i_dpd[0]};
            end
            default: begin
               case (i_dpd[6:5])
                  2'b00: begin
                     w_h = {3'b100, i_dpd[7]};
                     w_t = {3'b100, i_dpd[4]};
                     w_u = {1'b0, i_dpd[9:8], i_dpd[0]};
                  end
                  2'b01: begin
                     w_h = {3'b100, i_dpd[7]};
                     w_t = {1'b0, i_dpd[9:8], i_dpd[4]};
                     w_u = {3'b100, i_dpd[0]};
                  end
                  2'b10: begin
                     w_t = {3'b100, i_dpd[4]};
                     w_u = {3'b100, i_dpd[0]};
                  end
                  default: begin
                     w_h = {3'b100, i_dpd[7]};
                     w_t = {3'b100, i_dpd[4]};
                     w_u = {3'b100, i_dpd[0]};
                  end
               endcase
            end
         endcase
      end
   end

   assign o_bcd = {w_h, w_t, w_u};

endmodule

// File: rtl/dpd_conv_seq.sv
// Sequential binary / BCD / DPD converter over NDEC declets. Binary input is
// converted by double-dabble (one bit per cycle), binary output by Horner.
module dpd_conv_seq
   import dpd_conv_pkg::*;
#(
   parameter int NDEC = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 in_fmt,
   input  logic [1:0]                 out_fmt,
   input  logic [bcd_w(NDEC)-1:0]     in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [bcd_w(NDEC)-1:0]     out_data,
   output logic                       out_ovf,
   output logic [dig_cnt(NDEC)-1:0]   out_bad,
   output logic                       out_bad_any,
   output logic                       busy
);

   localparam int D   = dig_cnt(NDEC);
   localparam int W   = bin_w(NDEC);
   localparam int B   = bcd_w(NDEC);
   localparam int ND1 = D + 1;
   localparam int CW  = $clog2(W);

   logic [1:0]       r_state, w_nxt_state;
   logic [1:0]       r_out_fmt, w_out_fmt;
   logic [4*ND1-1:0] r_dig, w_nxt_dig, w_add3;
   logic [W-1:0]     r_sh, w_nxt_sh;
   logic [W-1:0]     r_acc, w_nxt_acc, w_acc_mac;
   logic [CW-1:0]    r_cnt, w_nxt_cnt;
   logic [3:0]       w_cur_dig;
   logic [B-1:0]     w_unpk, w_out_data, r_out_data;
   logic [W-1:0]     w_pack;
   logic [D-1:0]     w_out_bad, r_out_bad;
   logic             r_out_ovf, w_load_out, w_accept;

   assign w_accept = in_valid && (r_state == ST_IDLE);

   for (genvar g = 0; g < NDEC; g++) begin : g_declet
      dpd_unpack u_unpack (
         .i_dpd (in_data[10*g +: 10]),
         .o_bcd (w_unpk[12*g +: 12])
      );
      dpd_pack u_pack (
         .i_bcd (w_nxt_dig[12*g +: 12]),
         .o_dpd (w_pack[10*g +: 10])
      );
   end

   bcd_dabble_step #(.NDIG(ND1)) u_step (
      .i_dig (r_dig),
      .o_dig (w_add3)
   );

   always_comb begin
      w_cur_dig = '0;
      for (int i = 0; i < D; i++) begin
         if (r_cnt == CW'(i)) w_cur_dig = r_dig[4*i +: 4];
      end
   end

   // Horner step; the product wraps modulo 2^W by construction.
   assign w_acc_mac = (r_acc << 3) + (r_acc << 1) + W'(w_cur_dig);

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_dig   = r_dig;
      w_nxt_sh    = r_sh;
      w_nxt_acc   = r_acc;
      w_nxt_cnt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               w_nxt_acc = '0;
               if (in_fmt == FMT_BIN) begin
                  w_nxt_dig   = '0;
                  w_nxt_sh    = in_data[W-1:0];
                  w_nxt_cnt   = CW'(W - 1);
                  w_nxt_state = ST_BIN2BCD;
               end else begin
                  w_nxt_dig   = {4'h0, (in_fmt == FMT_BCD) ? in_data : w_unpk};
                  w_nxt_cnt   = CW'(D - 1);
                  w_nxt_state = (out_fmt == FMT_BIN) ? ST_BCD2BIN : ST_DONE;
               end
            end
         end
         ST_BIN2BCD: begin
            // Digits and binary shifter form one rotating register.
            w_nxt_dig = {w_add3[4*ND1-2:0], r_sh[W-1]};
            w_nxt_sh  = {r_sh[W-2:0], w_add3[4*ND1-1]};
            w_nxt_cnt = r_cnt - 1'b1;
            if (r_cnt == '0) begin
               w_nxt_cnt   = CW'(D - 1);
               w_nxt_state = (r_out_fmt == FMT_BIN) ? ST_BCD2BIN : ST_DONE;
            end
         end
         ST_BCD2BIN: begin
            w_nxt_acc = w_acc_mac;
            w_nxt_cnt = r_cnt - 1'b1;
            if (r_cnt == '0) w_nxt_state = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) w_nxt_state = ST_IDLE;
         end
         default: w_nxt_state = ST_IDLE;
      endcase
   end

   // Results are captured on the edge that enters DONE, from the next-state values.
   assign w_load_out = (w_nxt_state == ST_DONE) && (r_state != ST_DONE);
   assign w_out_fmt  = (r_state == ST_IDLE) ? out_fmt : r_out_fmt;

   always_comb begin
      w_out_data = '0;
      case (w_out_fmt)
         FMT_BIN:              w_out_data = {{(B-W){1'b0}}, w_nxt_acc};
         FMT_BCD:              w_out_data = w_nxt_dig[B-1:0];
         FMT_DPD, FMT_DPD_ALT: w_out_data = {{(B-W){1'b0}}, w_pack};
         default:              w_out_data = '0;
      endcase
      for (int i = 0; i < D; i++) begin
         w_out_bad[i] = (w_nxt_dig[4*i +: 4] > 4'd9);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_out_fmt  <= FMT_BIN;
         r_dig      <= '0;
         r_sh       <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_out_data <= '0;
         r_out_ovf  <= 1'b0;
         r_out_bad  <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_dig   <= w_nxt_dig;
         r_sh    <= w_nxt_sh;
         r_acc   <= w_nxt_acc;
         r_cnt   <= w_nxt_cnt;
         if (w_accept) r_out_fmt <= out_fmt;
         if (w_load_out) begin
            r_out_data <= w_out_data;
            r_out_ovf  <= |w_nxt_dig[4*ND1-1 -: 4];
            r_out_bad  <= w_out_bad;
         end
      end
   end

   assign in_ready    = (r_state == ST_IDLE);
   assign busy        = (r_state != ST_IDLE);
   assign out_valid   = (r_state == ST_DONE);
   assign out_data    = r_out_data;
   assign out_ovf     = r_out_ovf;
   assign out_bad     = r_out_bad;
   assign out_bad_any = |r_out_bad;

endmodule

// File: tb/tb_dpd_conv_seq.sv
// Self-checking bench for dpd_conv_seq (NDEC=2): directed cases, backpressure,
// mid-conversion reset and randomized traffic against an arithmetic model.
module tb_dpd_conv_seq;

   localparam int NDEC = 2;
   localparam int D    = 6;
   localparam int W    = 20;
   localparam int B    = 24;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_fmt = 2'b00;
   logic [1:0]    out_fmt = 2'b00;
   logic [B-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [B-1:0]  out_data;
   logic          out_ovf;
   logic [D-1:0]  out_bad;
   logic          out_bad_any;
   logic          busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dpd_conv_seq #(.NDEC(NDEC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_fmt      (in_fmt),
      .out_fmt     (out_fmt),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_ovf     (out_ovf),
      .out_bad     (out_bad),
      .out_bad_any (out_bad_any),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Canonical DPD encoding of three decimal digits; 8..15 keep only their LSB.
   function automatic logic [9:0] ref_pack(input int hv, input int tv, input int uv);
      logic [3:0] h, t, u;
      h = 4'(hv);
      t = 4'(tv);
      u = 4'(uv);
      if (h[3]) h = {3'b100, h[0]};
      if (t[3]) t = {3'b100, t[0]};
      if (u[3]) u = {3'b100, u[0]};
      case ({h[3], t[3], u[3]})
         3'b000:  return {h[2:0], t[2:0], 1'b0, u[2:0]};
         3'b001:  return {h[2:0], t[2:0], 3'b100, u[0]};
         3'b010:  return {h[2:0], u[2:1], t[0], 3'b101, u[0]};
         3'b011:  return {h[2:0], 2'b10, t[0], 3'b111, u[0]};
         3'b100:  return {u[2:1], h[0], t[2:0], 3'b110, u[0]};
         3'b101:  return {t[2:1], h[0], 2'b01, t[0], 3'b111, u[0]};
         3'b110:  return {u[2:1], h[0], 2'b00, t[0], 3'b111, u[0]};
         default: return {2'b00, h[0], 2'b11, t[0], 3'b111, u[0]};
      endcase
   endfunction

   // Decode a canonical declet by finding the value whose encoding matches.
   function automatic int ref_unpack(input logic [9:0] c);
      for (int v = 0; v < 1000; v++) begin
         if (ref_pack(v / 100, (v / 10) % 10, v % 10) == c) return v;
      end
      return 0;
   endfunction

   task automatic ref_model(input logic [1:0] fi, input logic [1:0] fo, input logic [B-1:0] din,
                            output logic [B-1:0] ed, output logic eovf,
                            output logic [D-1:0] ebad, output int elat);
      int     dig [D];
      longint v;
      longint wt;
      int     lo, hi;
      eovf = 1'b0;
      if (fi == 2'b00) begin
         v    = longint'(din[W-1:0]);
         eovf = (v >= 1000000);
         v    = v % 1000000;
         wt   = 1;
         for (int i = 0; i < D; i++) begin
            dig[i] = int'((v / wt) % 10);
            wt     = wt * 10;
         end
      end else if (fi == 2'b01) begin
         for (int i = 0; i < D; i++) dig[i] = int'(din[4*i +: 4]);
      end else begin
         lo = ref_unpack(din[9:0]);
         hi = ref_unpack(din[19:10]);
         dig[0] = lo % 10; dig[1] = (lo / 10) % 10; dig[2] = lo / 100;
         dig[3] = hi % 10; dig[4] = (hi / 10) % 10; dig[5] = hi / 100;
      end
      for (int i = 0; i < D; i++) ebad[i] = (dig[i] >= 10);
      ed = '0;
      if (fo == 2'b00) begin
         v  = 0;
         wt = 1;
         for (int i = 0; i < D; i++) begin
            v  = v + longint'(dig[i]) * wt;
            wt = wt * 10;
         end
         ed = B'(v % (64'd1 << W));
      end else if (fo == 2'b01) begin
         for (int i = 0; i < D; i++) ed[4*i +: 4] = 4'(dig[i]);
      end else begin
         ed = {4'h0, ref_pack(dig[5], dig[4], dig[3]), ref_pack(dig[2], dig[1], dig[0])};
      end
      elat = 1 + ((fi == 2'b00) ? W : 0) + ((fo == 2'b00) ? D : 0);
   endtask

   // One full transaction: accept, bounded wait for the result, compare, release.
   task automatic run_txn(input logic [1:0] fi, input logic [1:0] fo, input logic [B-1:0] din,
                          input logic [B-1:0] ed, input logic eovf,
                          input logic [D-1:0] ebad, input int elat);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_idle", in_ready, 1);
      in_fmt   = fi;
      out_fmt  = fo;
      in_data  = din;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = B'($urandom);
      in_fmt   = 2'($urandom);
      out_fmt  = 2'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 100);
      check("latency", n, elat);
      check("out_data", out_data, ed);
      check("out_ovf", out_ovf, eovf);
      check("out_bad", out_bad, ebad);
      check("out_bad_any", out_bad_any, |ebad);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("valid_drop", out_valid, 0);
      check("ready_back", in_ready, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]   fi, fo;
      logic [B-1:0] din, ed;
      logic         eovf;
      logic [D-1:0] ebad;
      int           elat;

      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_out_bad", out_bad, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_txn(2'b00, 2'b01, 24'd123456, 24'h123456, 1'b0, 6'b0, 21);
      run_txn(2'b00, 2'b01, 24'h0FFFFF, 24'h048575, 1'b1, 6'b0, 21);
      run_txn(2'b01, 2'b10, 24'h999999, 24'h03FCFF, 1'b0, 6'b0, 1);
      run_txn(2'b10, 2'b01, 24'h03FCFF, 24'h999999, 1'b0, 6'b0, 1);
      run_txn(2'b01, 2'b00, 24'h00A123, 24'h00278B, 1'b0, 6'b001000, 7);
      run_txn(2'b11, 2'b01, 24'hAFFFFF, 24'h999999, 1'b0, 6'b0, 1);
      run_txn(2'b00, 2'b00, 24'd999999, 24'd999999, 1'b0, 6'b0, 27);
      run_txn(2'b00, 2'b01, 24'd1000000, 24'h000000, 1'b1, 6'b0, 21);
      run_txn(2'b01, 2'b11, 24'h0000FE, 24'h00005E, 1'b0, 6'b000011, 1);

      // Backpressure: result held, new operands ignored while DONE.
      ref_model(2'b01, 2'b10, 24'h123456, ed, eovf, ebad, elat);
      in_fmt = 2'b01; out_fmt = 2'b10; in_data = 24'h123456; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         check("bp_data_held", out_data, ed);
         check("bp_flags_held", {out_ovf, out_bad}, {eovf, ebad});
         check("bp_in_ready_low", in_ready, 0);
         in_valid = (i % 2 == 0);
         in_fmt   = 2'b01;
         out_fmt  = 2'b01;
         in_data  = B'($urandom);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("bp_release_valid", out_valid, 0);
      check("bp_release_ready", in_ready, 1);
      @(negedge clk);
      check("bp_no_queue", busy, 0);

      // Reset part-way through a binary conversion.
      in_fmt = 2'b00; out_fmt = 2'b01; in_data = 24'd654321; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_ready", in_ready, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_flags", {out_ovf, out_bad}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_txn(2'b00, 2'b01, 24'd654321, 24'h654321, 1'b0, 6'b0, 21);

      for (int k = 0; k < 40; k++) begin
         fi = 2'($urandom_range(0, 3));
         fo = 2'($urandom_range(0, 3));
         if (fi == 2'b00) begin
            din = B'($urandom);
            if (k % 8 == 3) din[W-1:0] = 20'd999999;
         end else if (fi == 2'b01) begin
            din = B'($urandom);
         end else begin
            din = {4'($urandom),
                   ref_pack($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9)),
                   ref_pack($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9))};
         end
         ref_model(fi, fo, din, ed, eovf, ebad, elat);
         run_txn(fi, fo, din, ed, eovf, ebad, elat);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dpd_conv_seq.md
Name: dpd_conv_seq

Overview:
Parametrised sequential decimal-format converter over NDEC declets (3*NDEC decimal digits). It accepts one operand in binary, packed BCD or densely-packed-decimal (DPD) and returns it in any of the three formats. The binary path is iterative (double-dabble in, Horner out), so any digit count fits a small area. It sits between the pad-facing I/O wrapper and downstream decimal logic, with valid/ready handshakes on both sides.

Parameters:
NDEC, 2, number of declets; digits D=3*NDEC; binary/DPD width W=10*NDEC; BCD width B=12*NDEC.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand present
in_ready  output  1  block can accept (high only in IDLE)
in_fmt  input  2  operand format: 00 binary, 01 BCD, 10 DPD, 11 aliases DPD
out_fmt  input  2  result format, same encoding
in_data  input  B  operand; binary/DPD use bits [W-1:0], upper bits ignored
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_data  output  B  result; binary/DPD zero-extended to B
out_ovf  output  1  binary operand >= 10^D
out_bad  output  D  per-digit flag, digit value >= 10 (bit i = digit i, i=0 is LSD)
out_bad_any  output  1  OR of out_bad
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_data=0, all flags=0, busy=0, internal digit/accumulator registers=0.
- Accept happens on a clock edge with in_valid&&in_ready. in_fmt, out_fmt and in_data are captured at that edge. Inputs are ignored at all other times.
- States: IDLE -> BIN2BCD (in_fmt=00) or straight to the out step. BIN2BCD -> BCD2BIN (out_fmt=00) or DONE. DONE -> IDLE on out_ready.
- Internal canonical form: D+1 BCD digits (top digit is the overflow digit) plus a W-bit accumulator.
- BCD in: digits are loaded at accept, with no range correction.
- DPD in: each declet is unpacked combinationally and loaded at accept. Non-canonical DPD codes decode per standard and raise no flag.
- Binary in: double-dabble, one bit per cycle, W cycles (add 3 to each digit >=5, then shift).
  - out_ovf = overflow digit != 0.
  - The result digits are the value mod 10^D.
- BCD2BIN: Horner, acc = acc*10 + digit, MSD first, one digit per cycle, D cycles. Raw digit values are used (10..15 included). Arithmetic is mod 2^W.
- Output formats:
  - BCD out: digits are passed raw.
  - DPD out: per-declet pack using digit bit3 and bit0 for large digits, so 10..15 encode as 8/9 by LSB.
  - Binary out: the accumulator.
- out_bad is computed from the final digit register, so it is always 0 when in_fmt is binary or DPD.
- Latency: if the accept edge ends cycle k, out_valid is high from cycle k+1+Tin+Tout.
  - Tin = W if in_fmt=00, else 0.
  - Tout = D if out_fmt=00, else 0.
- out_data and the flags are registered. They stay stable while out_valid=1 and out_ready=0.
- In DONE, out_valid=1. When out_ready=1 at an edge, the next state is IDLE and out_valid drops.
- in_ready goes high the cycle after the transfer; there is no same-cycle turnaround.
- in_valid asserted while busy is ignored; it does not queue.
- Reset mid-conversion aborts immediately to the reset values. No partial result is emitted.

Decomposition:
- Shared package dpd_conv_pkg:
  - format codes FMT_BIN/FMT_BCD/FMT_DPD.
  - state enum {IDLE, BIN2BCD, BCD2BIN, DONE}.
  - width functions for D/W/B.
- Reuse the existing combinational dpd_pack and dpd_unpack, NDEC instances each via generate.
- One new sub-module is natural: bcd_dabble_step (combinational add-3 correction over D+1 digits).

Test Plan:
- NDEC=2, in_fmt=00, in_data=20'd123456, out_fmt=01 -> out_data=24'h123456, ovf=0, out_valid at k+21.
- in_fmt=00, in_data=20'hFFFFF (1048575), out_fmt=01 -> out_data=24'h048575, out_ovf=1.
- in_fmt=01, in_data=24'h999999, out_fmt=10 -> out_data=20'h3FCFF, latency k+1. Loop back with in_fmt=10, out_fmt=01 -> 24'h999999.
- in_fmt=01, in_data=24'h00A123, out_fmt=00 -> out_data=20'h0278B (10123), out_bad=6'b001000, out_bad_any=1, out_valid at k+7.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data/flags held, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE next cycle.
- Reset mid-BIN2BCD (cycle 10 of 20) -> outputs immediately 0, in_ready=1. After release, a new transaction converts correctly.
